// File: rtl/compress_frame_scheduler_if.sv
// Signal bundle between compress_frame_scheduler and the blocks around it: the pixel
// memory, the compress_block datapath and the downstream coefficient consumer.
interface compress_frame_scheduler_if #(
  parameter int ADDR_W = 16
);
  logic                        frame_start;
  logic                        mem_rd_en;
  logic [ADDR_W-1:0]           mem_addr;
  logic [7:0]                  mem_rd_data;
  logic signed [7:0][7:0][8:0] block;
  logic                        start_block;
  logic                        block_done;
  logic                        out_valid;
  logic                        out_ready;
  logic [7:0]                  out_bx;
  logic [7:0]                  out_by;
  logic                        out_last;
  logic                        busy;
  logic                        frame_done;
  logic                        err_timeout;

  modport master (
    input  frame_start, mem_rd_data, block_done, out_ready,
    output mem_rd_en, mem_addr, block, start_block, out_valid, out_bx, out_by,
           out_last, busy, frame_done, err_timeout
  );

  modport slave (
    output frame_start, mem_rd_data, block_done, out_ready,
    input  mem_rd_en, mem_addr, block, start_block, out_valid, out_bx, out_by,
           out_last, busy, frame_done, err_timeout
  );
endinterface

// File: rtl/compress_frame_scheduler.sv
// Frame sequencer for compress_block: raster-order 8x8 fetch, start/done, coordinate handoff.
// Optional block_done watchdog is enabled by defining SCHED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for frame_start
// FETCH | 64 pixel reads issued, each captured one cycle later
// START | one-cycle start_block pulse
// WAIT  | waiting for block_done (watchdog under SCHED_TIMEOUT_EN)
// EMIT  | out_valid held with stable coordinates until out_ready
// DONE  | one-cycle frame_done pulse
module compress_frame_scheduler #(
  parameter int IMG_W_BLKS     = 4,
  parameter int IMG_H_BLKS     = 4,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                        clk,
  input logic                        rst_n,
  compress_frame_scheduler_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST_BX   = 8'(IMG_W_BLKS - 1);
  localparam logic [7:0] LAST_BY   = 8'(IMG_H_BLKS - 1);
  localparam int         ROW_PITCH = IMG_W_BLKS * 8;

  if (IMG_W_BLKS < 1 || IMG_H_BLKS < 1 || IMG_W_BLKS > 256 || IMG_H_BLKS > 256 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("compress_frame_scheduler: image size or timeout parameter out of range");
  end

  state_t               state;
  state_t               state_nxt;
  logic [7:0]           bx;
  logic [7:0]           by;
  logic [6:0]           issue_cnt;
  logic                 cap_vld;
  logic [5:0]           cap_idx;
  logic [7:0][7:0][8:0] blk_q;
  logic                 last_blk;
  logic                 issuing;
  logic                 accept;
  logic                 fetch_done;
  logic                 expire;
  logic                 err_q;

  assign last_blk   = (bx == LAST_BX) && (by == LAST_BY);
  assign issuing    = (state == S_FETCH) && !issue_cnt[6];
  assign accept     = (state == S_EMIT) && bus.out_ready;
  assign fetch_done = cap_vld && (cap_idx == 6'd63);

`ifdef SCHED_TIMEOUT_EN
  localparam int              WT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(TIMEOUT_CYCLES - 1);

  logic [WT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + WT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // block_done arriving on the expiry cycle takes priority over the error
  assign expire = (state == S_WAIT) && !bus.block_done && (wait_cnt == WT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && bus.frame_start) begin
      err_q <= 1'b0;
    end else if (expire) begin
      err_q <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  assign err_q  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.frame_start) state_nxt = S_FETCH;
      S_FETCH: if (fetch_done) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.block_done) begin
          state_nxt = S_EMIT;
        end else if (expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_EMIT:  if (bus.out_ready) state_nxt = last_blk ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_en   = issuing;
    bus.start_block = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_last    = 1'b0;
    bus.frame_done  = 1'b0;
    bus.busy        = (state != S_IDLE);
    case (state)
      S_START: bus.start_block = 1'b1;
      S_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_blk;
      end
      S_DONE:  bus.frame_done = 1'b1;
      default: ;
    endcase
  end

  // Block coordinates, fetch counters and the captured block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx        <= '0;
      by        <= '0;
      issue_cnt <= '0;
      cap_vld   <= 1'b0;
      cap_idx   <= '0;
      blk_q     <= '0;
    end else begin
      cap_vld <= issuing;
      cap_idx <= issue_cnt[5:0];
      if (state == S_IDLE && bus.frame_start) begin
        bx        <= '0;
        by        <= '0;
        issue_cnt <= '0;
      end
      if (issuing) begin
        issue_cnt <= issue_cnt + 7'd1;
      end
      if (cap_vld) begin
        blk_q[cap_idx[5:3]][cap_idx[2:0]] <= {1'b0, bus.mem_rd_data} - 9'd128;
      end
      if (accept) begin
        issue_cnt <= '0;
        if (bx == LAST_BX) begin
          bx <= '0;
          by <= (by == LAST_BY) ? 8'd0 : by + 8'd1;
        end else begin
          bx <= bx + 8'd1;
        end
      end
    end
  end

  // {by,r} is the image pixel row and {bx,c} the pixel column
  assign bus.mem_addr = ADDR_W'(32'({by, issue_cnt[5:3]}) * 32'(ROW_PITCH) +
                                32'({bx, issue_cnt[2:0]}));

  assign bus.out_bx      = bx;
  assign bus.out_by      = by;
  assign bus.block       = blk_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_compress_frame_scheduler.sv
// Bench for compress_frame_scheduler: a 2x2-block instance driven from a per-block vector
// table and a 1x1-block instance for exact cycle timing; pixel memory holds addr[7:0].
module tb_compress_frame_scheduler;
  localparam int ADDR_W = 16;

  typedef struct {
    int         done_dly;
    int         stall;
    bit         spur_done;
    bit         spur_start;
    logic [7:0] bx;
    logic [7:0] by;
    bit         last;
    int         first_addr;
  } blk_vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   fd_a = 0;
  int   fd_b = 0;

  always #5 clk = ~clk;

  compress_frame_scheduler_if #(.ADDR_W(ADDR_W)) ifa ();
  compress_frame_scheduler_if #(.ADDR_W(ADDR_W)) ifb ();

  compress_frame_scheduler #(
    .IMG_W_BLKS(2), .IMG_H_BLKS(2), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.master)
  );

  compress_frame_scheduler #(
    .IMG_W_BLKS(1), .IMG_H_BLKS(1), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.master)
  );

  always @(posedge clk) begin
    if (ifa.mem_rd_en) ifa.mem_rd_data <= ifa.mem_addr[7:0];
    if (ifb.mem_rd_en) ifb.mem_rd_data <= ifb.mem_addr[7:0];
    if (ifa.frame_done) fd_a <= fd_a + 1;
    if (ifb.frame_done) fd_b <= fd_b + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected level-shifted pixel for the 2x2 image (16 pixels per row)
  function automatic logic [8:0] px9(input int bx, input int by, input int r, input int c);
    int a;
    a = ((by * 8 + r) * 16 + bx * 8 + c) & 255;
    return 9'(a) - 9'd128;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    blk_vec_t vec[4];
    int       n;
    int       fd0;

    vec[0] = '{13, 0,  1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 0};
    vec[1] = '{3,  10, 1'b0, 1'b1, 8'd1, 8'd0, 1'b0, 8};
    vec[2] = '{0,  2,  1'b0, 1'b0, 8'd0, 8'd1, 1'b0, 128};
    vec[3] = '{5,  1,  1'b1, 1'b1, 8'd1, 8'd1, 1'b1, 136};

    rst_n = 1'b0;
    ifa.frame_start = 1'b0; ifa.block_done = 1'b0; ifa.out_ready = 1'b0;
    ifb.frame_start = 1'b0; ifb.block_done = 1'b0; ifb.out_ready = 1'b0;
    repeat (3) tick();
    chk("por_busy", ifa.busy, 0);
    chk("por_addr", ifa.mem_addr, 0);
    chk("por_last_1x1", ifb.out_last, 0);
    rst_n = 1'b1;
    tick();

    // 1x1 frame with exact cycle numbering (cycle 1 = first cycle after frame_start edge)
    cyc = 0;
    ifb.frame_start = 1'b1; tick(); ifb.frame_start = 1'b0;
    chk("b_rd_en_c1", ifb.mem_rd_en, 1);
    chk("b_addr_c1", ifb.mem_addr, 0);
    while (cyc < 64) tick();
    chk("b_rd_en_c64", ifb.mem_rd_en, 1);
    chk("b_addr_c64", ifb.mem_addr, 63);
    tick();
    chk("b_rd_en_c65", ifb.mem_rd_en, 0);
    chk("b_start_c65", ifb.start_block, 0);
    tick();
    chk("b_start_c66", ifb.start_block, 1);
    tick();
    chk("b_start_c67", ifb.start_block, 0);
    chk("b_busy_c67", ifb.busy, 1);
    while (cyc < 80) tick();
    chk("b_valid_c80", ifb.out_valid, 0);
    chk("b_last_c80", ifb.out_last, 0);
    ifb.block_done = 1'b1; tick(); ifb.block_done = 1'b0;
    chk("b_valid_c81", ifb.out_valid, 1);
    chk("b_last_c81", ifb.out_last, 1);
    chk("b_bx", ifb.out_bx, 0);
    chk("b_by", ifb.out_by, 0);
    chk("b_blk00", ifb.block[0][0], 9'h180);
    chk("b_blk77", ifb.block[7][7], 9'h1BF);
    chk("b_blk34", ifb.block[3][4], 9'h19C);
    ifb.out_ready = 1'b1; tick(); ifb.out_ready = 1'b0;
    chk("b_frame_done", ifb.frame_done, 1);
    chk("b_valid_after_hs", ifb.out_valid, 0);
    tick();
    chk("b_frame_done_1cyc", ifb.frame_done, 0);
    chk("b_idle", ifb.busy, 0);
    chk("b_fd_count", fd_b, 1);

    // Reset in the middle of FETCH on the 2x2 instance
    ifa.frame_start = 1'b1; tick(); ifa.frame_start = 1'b0;
    repeat (20) tick();
    chk("a_busy_fetch", ifa.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_rd_en", ifa.mem_rd_en, 0);
    chk("rst_addr", ifa.mem_addr, 0);
    chk("rst_start", ifa.start_block, 0);
    chk("rst_valid", ifa.out_valid, 0);
    chk("rst_last", ifa.out_last, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_fdone", ifa.frame_done, 0);
    chk("rst_err", ifa.err_timeout, 0);
    chk("rst_bx", ifa.out_bx, 0);
    chk("rst_by", ifa.out_by, 0);
    chk("rst_block_zero", (ifa.block == '0), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("a_no_fd_after_rst", fd_a, 0);

    // 2x2 frame from the vector table
    ifa.frame_start = 1'b1; tick(); ifa.frame_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("a%0d_rd_en_first", k), ifa.mem_rd_en, 1);
      chk($sformatf("a%0d_first_addr", k), ifa.mem_addr, vec[k].first_addr);
      n = 1;
      while (ifa.start_block !== 1'b1 && n < 100) begin
        ifa.block_done = vec[k].spur_done && (n == 10);
        tick();
        n++;
      end
      ifa.block_done = 1'b0;
      chk($sformatf("a%0d_start_cycle", k), n, 66);
      tick();
      for (int d = 0; d < vec[k].done_dly; d++) begin
        ifa.frame_start = vec[k].spur_start && (d == 1);
        tick();
      end
      ifa.frame_start = 1'b0;
      chk($sformatf("a%0d_wait_valid", k), ifa.out_valid, 0);
      chk($sformatf("a%0d_wait_rd_en", k), ifa.mem_rd_en, 0);
      ifa.block_done = 1'b1; tick(); ifa.block_done = 1'b0;
      chk($sformatf("a%0d_valid", k), ifa.out_valid, 1);
      chk($sformatf("a%0d_bx", k), ifa.out_bx, vec[k].bx);
      chk($sformatf("a%0d_by", k), ifa.out_by, vec[k].by);
      chk($sformatf("a%0d_last", k), ifa.out_last, vec[k].last);
      chk($sformatf("a%0d_blk00", k), ifa.block[0][0], px9(vec[k].bx, vec[k].by, 0, 0));
      chk($sformatf("a%0d_blk77", k), ifa.block[7][7], px9(vec[k].bx, vec[k].by, 7, 7));
      chk($sformatf("a%0d_blk25", k), ifa.block[2][5], px9(vec[k].bx, vec[k].by, 2, 5));
      for (int s = 0; s < vec[k].stall; s++) begin
        tick();
        chk($sformatf("a%0d_stall_valid", k), ifa.out_valid, 1);
        chk($sformatf("a%0d_stall_bx", k), ifa.out_bx, vec[k].bx);
        chk($sformatf("a%0d_stall_by", k), ifa.out_by, vec[k].by);
        chk($sformatf("a%0d_stall_rd_en", k), ifa.mem_rd_en, 0);
        chk($sformatf("a%0d_stall_blk77", k), ifa.block[7][7],
            px9(vec[k].bx, vec[k].by, 7, 7));
      end
      ifa.out_ready = 1'b1; tick(); ifa.out_ready = 1'b0;
      if (vec[k].last) begin
        chk("a_frame_done", ifa.frame_done, 1);
        tick();
        chk("a_frame_done_1cyc", ifa.frame_done, 0);
        chk("a_idle_after_frame", ifa.busy, 0);
        chk("a_fd_count", fd_a, 1);
      end else begin
        chk($sformatf("a%0d_no_fdone", k), ifa.frame_done, 0);
      end
    end

    // Never answer block_done
    ifa.frame_start = 1'b1; tick(); ifa.frame_start = 1'b0;
    n = 1;
    while (ifa.start_block !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("t_start_cycle", n, 66);
    tick();
    fd0 = fd_a;
`ifdef SCHED_TIMEOUT_EN
    repeat (15) tick();
    chk("t_err_before", ifa.err_timeout, 0);
    chk("t_busy_before", ifa.busy, 1);
    tick();
    chk("t_err_at_16", ifa.err_timeout, 1);
    chk("t_idle_at_16", ifa.busy, 0);
    chk("t_valid_at_16", ifa.out_valid, 0);
    tick();
    chk("t_err_sticky", ifa.err_timeout, 1);
    chk("t_no_fdone", fd_a, fd0);
    ifa.frame_start = 1'b1; tick(); ifa.frame_start = 1'b0;
    chk("t_err_cleared", ifa.err_timeout, 0);
    chk("t_restarted", ifa.busy, 1);
`else
    repeat (40) tick();
    chk("t_still_waiting", ifa.busy, 1);
    chk("t_no_err", ifa.err_timeout, 0);
    chk("t_no_valid", ifa.out_valid, 0);
    chk("t_no_fdone", fd_a, fd0);
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t_idle_after_rst", ifa.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/compress_frame_scheduler.md
# compress_frame_scheduler

Frame-level controller that sequences the `compress_block` DCT/quantization datapath across a whole image. It fetches each 8x8 pixel block in raster order from a synchronous-read pixel memory and level-shifts it to signed 9-bit. It then pulses `start_block`, waits for `block_done`, and presents the block's coordinates on a valid/ready handshake so downstream entropy coding can read `quantized_coeffs` while they are held stable. It sits between the frame memory and `compress_block`, one instance per datapath.

## Interface
- `IMG_W_BLKS`, default 4: image width in 8x8 blocks (≥1).
- `IMG_H_BLKS`, default 4: image height in blocks (≥1).
- `ADDR_W`, default 16: pixel memory address width; must cover `IMG_W_BLKS*IMG_H_BLKS*64`.
- `TIMEOUT_CYCLES`, default 1024: `block_done` watchdog limit; used only under `SCHED_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: start a frame; sampled only in IDLE.
- `mem_rd_en` out 1: pixel memory read strobe.
- `mem_addr` out ADDR_W: pixel address, row-major, `(by*8+r)*(IMG_W_BLKS*8) + bx*8 + c`.
- `mem_rd_data` in 8: unsigned pixel, valid exactly 1 cycle after `mem_rd_en`.
- `block` out 9 signed [7:0][7:0]: level-shifted block driven to `compress_block`.
- `start_block` out 1: single-cycle start pulse.
- `block_done` in 1: completion pulse from `compress_block`.
- `out_valid` out 1: coefficients for the current block are ready.
- `out_ready` in 1: downstream accept.
- `out_bx` out 8: block column index.
- `out_by` out 8: block row index.
- `out_last` out 1: the current block is the final block of the frame.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: single-cycle pulse after the last block is accepted.
- `err_timeout` out 1: sticky watchdog error.

## Operation
- States: IDLE, FETCH, START, WAIT, EMIT, DONE.
- **IDLE**:
  - `frame_start`=1 clears `bx`, `by`, and the fetch counters, then goes to FETCH.
  - Also clears `err_timeout`.
- **FETCH**:
  - Issue counter `i` runs 0..63, giving `r=i[5:3]` and `c=i[2:0]`.
  - `mem_rd_en`=1 while `i`≤63.
  - A one-cycle-delayed capture strobe writes `block[r][c] = {1'b0,mem_rd_data} - 9'd128`, giving range -128..127.
  - After the 64th capture, go to START.
- **START**: `start_block`=1 for exactly this cycle, then go to WAIT.
- **WAIT**:
  - `block_done`=1 goes to EMIT.
  - `block_done` in any other state is ignored.
- **EMIT**:
  - `out_valid`=1; `out_bx`, `out_by`, and `out_last` are stable.
  - On `out_valid&&out_ready`, advance: `bx+1`; when `bx` wraps from `IMG_W_BLKS-1` to 0, do `by+1`.
  - If `out_last`, go to DONE; otherwise go to FETCH.
- **DONE**: `frame_done`=1 for one cycle, then go to IDLE.
- `block` holds from the last capture until the next block's first capture, so it is stable throughout START/WAIT/EMIT.
- `out_last = (bx==IMG_W_BLKS-1)&&(by==IMG_H_BLKS-1)`.
- `frame_start` outside IDLE is ignored; there is no queuing.
- Reset mid-operation: all state is abandoned and the block returns to IDLE. No `frame_done` is issued.

## Timing
- Reset values: state IDLE; `mem_rd_en`, `start_block`, `out_valid`, `out_last`, `busy`, `frame_done`, and `err_timeout` all 0; `mem_addr`=0; `out_bx`=`out_by`=0; all `block` entries 0.
- Taking cycle 0 as the edge where `frame_start` is sampled:
  - `mem_rd_en` is high on cycles 1..64.
  - Captures occur on cycles 2..65.
  - `start_block` is high on cycle 66.
  - WAIT begins on cycle 67.
- `out_valid` rises the cycle after `block_done` is sampled.
- After the EMIT handshake, the next FETCH begins on the following cycle. Per-block overhead beyond compute is 68 cycles plus downstream stall.
- `frame_done` is high on the cycle after the final handshake.
- `out_valid` never drops without a handshake, and its payload never changes while valid and not ready.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - A WAIT-state counter starts at 0 on entry.
  - If it reaches `TIMEOUT_CYCLES` with no `block_done`, set `err_timeout`=1 (sticky until the next accepted `frame_start` or reset) and go to IDLE without `frame_done`.
  - `block_done` on the same cycle as expiry wins; there is no error.
- Not defined: the counter is absent, WAIT waits indefinitely, and `err_timeout` is tied to 0.

## Test plan
- **Reset**: assert `rst_n`=0 mid-FETCH. Required: all outputs at reset values; `frame_start` after release starts a frame from `bx`=`by`=0.
- **Single 1x1 frame**: memory holds pixel `k` = `k`. Required: `block[r][c]` = 8r+c-128 (`block[0][0]`=-128, `block[7][7]`=-65); `start_block` at cycle 66; `block_done` at 80 gives `out_valid` at 81 with `out_last`=1; `frame_done` one cycle after the handshake.
- **2x2 frame**: emitted (bx,by) sequence is (0,0),(1,0),(0,1),(1,1). Block (1,0) first address is 8; block (0,1) first address is 128. `out_last` is high only on the 4th block.
- **Backpressure**: hold `out_ready`=0 for 10 cycles in EMIT. Required: `out_valid` and indices stable, `block` unchanged, no `mem_rd_en`; accept on cycle 11.
- **Spurious inputs**: `frame_start` during WAIT and `block_done` during FETCH. Required: no effect on state or counters.
- **Timeout** (`SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): never pulse `block_done`. Required: `err_timeout`=1 16 cycles after WAIT entry, return to IDLE, no `frame_done`; cleared by the next `frame_start`.
